frame_mapper: RTL

Transmit-side counterpart of the receive demapper: accepts client payload bytes from the rx AXIS FIFO and builds fixed-size line frames for the serial transmitter. Each frame carries a FAS, one overhead byte with the ARQ indication, the payload, and a trailing CRC-8. The receiver's position counter, CRC check and payload extraction consume this frame layout.

---
 rtl/frame_mapper.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/frame_mapper.sv
// frame_mapper
//   Transmit-side line framer. Pulls client payload bytes and emits
//   fixed-size frames of N = ROWS*COLS bytes:
//     k=0 FAS1 (0xF6, fas strobe), k=1 FAS2 (0x28),
//     k=2 OH = {6'b0, arq_present, arq_en}, k=3..N-2 payload, k=N-1 CRC-8.
//   The CRC-8 (poly 0x07, init 0, MSB first) covers payload bytes only.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-low reset
//   i_pyld_data/_valid        client payload byte + valid
//   o_pyld_data_ready         mapper takes the payload byte this cycle
//   o_frame_data/_valid/_fas  line byte, valid, first-FAS-byte strobe
//   i_frame_ready             serial transmitter accepts the line byte
//   i_arq_en/_valid           ARQ indication to signal to the far end
//   o_crc_val                 CRC of the most recently completed frame
module frame_mapper #(
    parameter int ROWS = 4,     // 1..4
    parameter int COLS = 1024   // 4..2047
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_pyld_data,
    input  logic       i_pyld_data_valid,
    output logic       o_pyld_data_ready,
    output logic [7:0] o_frame_data,
    output logic       o_frame_data_valid,
    output logic       o_frame_data_fas,
    input  logic       i_frame_ready,
    input  logic       i_arq_en,
    input  logic       i_arq_en_valid,
    output logic [7:0] o_crc_val
);

    localparam logic [7:0]  FAS1_BYTE = 8'hF6;
    localparam logic [7:0]  FAS2_BYTE = 8'h28;
    localparam int          N         = ROWS * COLS;
    // With ROWS=1, COLS=4 the frame has no payload: OH is followed by CRC.
    localparam bit          HAS_PYLD  = (N > 4);
    localparam logic [1:0]  ROW_LAST  = 2'(ROWS - 1);
    localparam logic [10:0] COL_LAST  = 11'(COLS - 1);
    // The last payload byte (k=N-2) always sits on the last row.
    localparam logic [10:0] COL_PLAST = 11'(COLS - 2);

    typedef enum logic [2:0] {
        S_FAS1,
        S_FAS2,
        S_OH,
        S_PYLD,
        S_CRC
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  row;
    logic [10:0] col;
    logic [7:0]  crc_acc;
    logic        arq_pend_present;
    logic        arq_pend_en;

    logic        load_ok;
    logic        load;
    logic        last_pyld;
    logic [7:0]  load_byte;
    logic [7:0]  oh_byte;

    // One byte step of the CRC-8, MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // NOTE: every signal gets a default at the top of the block, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        load_ok           = !o_frame_data_valid | i_frame_ready;
        o_pyld_data_ready = (state == S_PYLD) & load_ok;
        load              = (state == S_PYLD) ? (o_pyld_data_ready & i_pyld_data_valid) : load_ok;
        last_pyld         = (row == ROW_LAST) && (col == COL_PLAST);
        // A pulse coinciding with the OH load wins over the pending value.
        oh_byte           = i_arq_en_valid ? {6'b0, 1'b1, i_arq_en}
                                           : {6'b0, arq_pend_present, arq_pend_en};
        load_byte         = 8'h00;
        state_nxt         = state;
        case (state)
            S_FAS1: begin
                load_byte = FAS1_BYTE;
                if (load) state_nxt = S_FAS2;
            end
            S_FAS2: begin
                load_byte = FAS2_BYTE;
                if (load) state_nxt = S_OH;
            end
            S_OH: begin
                load_byte = oh_byte;
                if (load) state_nxt = HAS_PYLD ? S_PYLD : S_CRC;
            end
            S_PYLD: begin
                load_byte = i_pyld_data;
                if (load && last_pyld) state_nxt = S_CRC;
            end
            S_CRC: begin
                load_byte = crc_acc;
                if (load) state_nxt = S_FAS1;
            end
            default: state_nxt = S_FAS1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_FAS1;
        else        state <= state_nxt;
    end

    // NOTE: all registers here are control/datapath flops with a defined
    // reset value; a reset mid-frame drops the partial frame on the spot.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_frame_data       <= 8'h00;
            o_frame_data_valid <= 1'b0;
            o_frame_data_fas   <= 1'b0;
            o_crc_val          <= 8'h00;
            crc_acc            <= 8'h00;
            row                <= 2'd0;
            col                <= 11'd0;
        end else begin
            if (load) begin
                o_frame_data       <= load_byte;
                o_frame_data_valid <= 1'b1;
                o_frame_data_fas   <= (state == S_FAS1);
                if (col == COL_LAST) begin
                    col <= 11'd0;
                    row <= (row == ROW_LAST) ? 2'd0 : row + 2'd1;
                end else begin
                    col <= col + 11'd1;
                end
                case (state)
                    S_FAS1:  crc_acc   <= 8'h00;
                    S_PYLD:  crc_acc   <= crc8_byte(crc_acc, i_pyld_data);
                    S_CRC:   o_crc_val <= crc_acc;
                    default: ;
                endcase
            end else if (load_ok) begin
                // Register emptied (or already empty) with nothing to load.
                o_frame_data_valid <= 1'b0;
                o_frame_data_fas   <= 1'b0;
            end
        end
    end

    // Pending ARQ indication, consumed by the OH byte.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            arq_pend_present <= 1'b0;
            arq_pend_en      <= 1'b0;
        end else if (load && (state == S_OH)) begin
            arq_pend_present <= 1'b0;
            arq_pend_en      <= 1'b0;
        end else if (i_arq_en_valid) begin
            arq_pend_present <= 1'b1;
            arq_pend_en      <= i_arq_en;
        end
    end

endmodule
